// File: rtl/regsel_pkg.sv
// Shared constants and types for the LEGv8 register-select unit.
// Consumers guard the forwarding path with the REGSEL_FWD_EN macro.
package regsel_pkg;

    localparam int NREG_DEF = 32;
    localparam int ZR_IDX   = NREG_DEF - 1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_IW   = 3'd3,
        CLS_D    = 3'd4,
        CLS_CB   = 3'd5,
        CLS_B    = 3'd6
    } insn_cls_e;

    // Resolve overlapping decoder outputs: r > i > iw > d > cb > b.
    function automatic insn_cls_e class_encode(
        input logic r_type,
        input logic i_type,
        input logic iw_type,
        input logic d_type,
        input logic cb_type,
        input logic b_type
    );
        insn_cls_e cls;
        if (r_type) begin
            cls = CLS_R;
        end else if (i_type) begin
            cls = CLS_I;
        end else if (iw_type) begin
            cls = CLS_IW;
        end else if (d_type) begin
            cls = CLS_D;
        end else if (cb_type) begin
            cls = CLS_CB;
        end else if (b_type) begin
            cls = CLS_B;
        end else begin
            cls = CLS_NONE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/regsel_pipe_if.sv
// ID-stage decode inputs and select/hazard outputs of regsel_pipe.
// Forwarding codes exist only when REGSEL_FWD_EN is defined.
interface regsel_pipe_if #(
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            id_valid;
    logic            r_type;
    logic            i_type;
    logic            iw_type;
    logic            d_type;
    logic            cb_type;
    logic            b_type;
    logic            is_load;
    logic [AW-1:0]   rn_addr;
    logic [AW-1:0]   rm_addr;
    logic [AW-1:0]   rd_addr;
    logic [NREG-1:0] Asel;
    logic [NREG-1:0] Bsel;
    logic [NREG-1:0] Dsel_EX;
    logic [NREG-1:0] Dsel_MEM;
    logic [NREG-1:0] Dsel_WB;
    logic            stall;
`ifdef REGSEL_FWD_EN
    logic [1:0]      fwd_a_EX;
    logic [1:0]      fwd_b_EX;

    modport master (
        output id_valid, r_type, i_type, iw_type, d_type, cb_type, b_type,
        output is_load, rn_addr, rm_addr, rd_addr,
        input  Asel, Bsel, Dsel_EX, Dsel_MEM, Dsel_WB, stall, fwd_a_EX, fwd_b_EX
    );

    modport slave (
        input  id_valid, r_type, i_type, iw_type, d_type, cb_type, b_type,
        input  is_load, rn_addr, rm_addr, rd_addr,
        output Asel, Bsel, Dsel_EX, Dsel_MEM, Dsel_WB, stall, fwd_a_EX, fwd_b_EX
    );
`else
    modport master (
        output id_valid, r_type, i_type, iw_type, d_type, cb_type, b_type,
        output is_load, rn_addr, rm_addr, rd_addr,
        input  Asel, Bsel, Dsel_EX, Dsel_MEM, Dsel_WB, stall
    );

    modport slave (
        input  id_valid, r_type, i_type, iw_type, d_type, cb_type, b_type,
        input  is_load, rn_addr, rm_addr, rd_addr,
        output Asel, Bsel, Dsel_EX, Dsel_MEM, Dsel_WB, stall
    );
`endif

endinterface

// File: rtl/regsel_pipe_onehot_decoder.sv
// Binary register address to one-hot select; a low enable yields all zeros.
module onehot_decoder #(
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            en_i,
    input  logic [AW-1:0]   addr_i,
    output logic [NREG-1:0] sel_o
);

    // One compare per select line keeps non-power-of-two NREG safe.
    always_comb begin
        sel_o = {NREG{1'b0}};
        for (int k = 0; k < NREG; k++) begin
            sel_o[k] = en_i && (addr_i == AW'(k));
        end
    end

endmodule

// File: rtl/regsel_pipe.sv
// Operand/destination register-select unit with RAW hazard detection.
// Define REGSEL_FWD_EN for forwarding codes (only load-use then stalls).
module regsel_pipe
    import regsel_pkg::*;
#(
    parameter int NREG = 32,
    parameter int ZR   = NREG - 1
) (
    input  logic         clk,
    input  logic         reset_n,
    regsel_pipe_if.slave bus
);

    localparam int              AW    = $clog2(NREG);
    localparam logic [AW-1:0]   ZR_A  = AW'(ZR);
    localparam logic [NREG-1:0] ZR_OH = NREG'(1) << ZR;

    insn_cls_e       cls_s;
    logic            a_en_s;
    logic            b_en_s;
    logic [AW-1:0]   a_addr_s;
    logic [AW-1:0]   b_addr_s;
    logic [AW-1:0]   d_addr_s;
    logic [AW-1:0]   d_next_addr_s;
    logic [NREG-1:0] asel_s;
    logic [NREG-1:0] bsel_s;
    logic [NREG-1:0] dsel_s;
    logic            a_ex_s;
    logic            b_ex_s;
    logic            a_mem_s;
    logic            b_mem_s;
    logic            stall_s;

    logic [NREG-1:0] dsel_ex_d,  dsel_ex_q;
    logic [NREG-1:0] dsel_mem_d, dsel_mem_q;
    logic [NREG-1:0] dsel_wb_d,  dsel_wb_q;
    logic            ex_load_d,  ex_load_q;

    // Class decode and per-class source/destination mapping.
    always_comb begin
        cls_s    = CLS_NONE;
        a_en_s   = 1'b0;
        b_en_s   = 1'b0;
        a_addr_s = bus.rn_addr;
        b_addr_s = bus.rm_addr;
        d_addr_s = ZR_A;
        if (bus.id_valid) begin
            cls_s = class_encode(bus.r_type, bus.i_type, bus.iw_type,
                                 bus.d_type, bus.cb_type, bus.b_type);
        end else begin
            cls_s = CLS_NONE;
        end
        case (cls_s)
            CLS_R: begin
                a_en_s   = 1'b1;
                b_en_s   = 1'b1;
                d_addr_s = bus.rd_addr;
            end
            CLS_I: begin
                a_en_s   = 1'b1;
                d_addr_s = bus.rd_addr;
            end
            CLS_IW: begin
                d_addr_s = bus.rd_addr;
            end
            CLS_D: begin
                a_en_s   = 1'b1;
                b_en_s   = 1'b1;
                b_addr_s = bus.rd_addr;
                d_addr_s = bus.is_load ? bus.rd_addr : ZR_A;
            end
            CLS_CB: begin
                b_en_s   = 1'b1;
                b_addr_s = bus.rd_addr;
            end
            CLS_B: begin
                d_addr_s = ZR_A;
            end
            default: begin
                d_addr_s = ZR_A;
            end
        endcase
    end

    // Bubble stages hold ZR, so they can never match a live source.
    always_comb begin
        a_ex_s  = 1'b0;
        b_ex_s  = 1'b0;
        a_mem_s = 1'b0;
        b_mem_s = 1'b0;
        if (a_en_s && (a_addr_s != ZR_A)) begin
            a_ex_s  = dsel_ex_q[a_addr_s];
            a_mem_s = dsel_mem_q[a_addr_s];
        end else begin
            a_ex_s  = 1'b0;
            a_mem_s = 1'b0;
        end
        if (b_en_s && (b_addr_s != ZR_A)) begin
            b_ex_s  = dsel_ex_q[b_addr_s];
            b_mem_s = dsel_mem_q[b_addr_s];
        end else begin
            b_ex_s  = 1'b0;
            b_mem_s = 1'b0;
        end
    end

`ifdef REGSEL_FWD_EN
    assign stall_s = ex_load_q && (a_ex_s || b_ex_s);
`else
    assign stall_s = (ex_load_q && (a_ex_s || b_ex_s)) ||
                     a_ex_s || b_ex_s || a_mem_s || b_mem_s;
`endif

    assign d_next_addr_s = stall_s ? ZR_A : d_addr_s;

    onehot_decoder #(.NREG(NREG)) u_dec_a (
        .en_i   (a_en_s),
        .addr_i (a_addr_s),
        .sel_o  (asel_s)
    );

    onehot_decoder #(.NREG(NREG)) u_dec_b (
        .en_i   (b_en_s),
        .addr_i (b_addr_s),
        .sel_o  (bsel_s)
    );

    onehot_decoder #(.NREG(NREG)) u_dec_d (
        .en_i   (1'b1),
        .addr_i (d_next_addr_s),
        .sel_o  (dsel_s)
    );

    // Destination pipeline next state; a stall injects a bubble into EX.
    always_comb begin
        dsel_ex_d  = dsel_s;
        dsel_mem_d = dsel_ex_q;
        dsel_wb_d  = dsel_mem_q;
        ex_load_d  = 1'b0;
        if (!stall_s && (cls_s == CLS_D) && bus.is_load) begin
            ex_load_d = 1'b1;
        end else begin
            ex_load_d = 1'b0;
        end
    end

    // Destination pipeline registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dsel_ex_q  <= ZR_OH;
            dsel_mem_q <= ZR_OH;
            dsel_wb_q  <= ZR_OH;
            ex_load_q  <= 1'b0;
        end else begin
            dsel_ex_q  <= dsel_ex_d;
            dsel_mem_q <= dsel_mem_d;
            dsel_wb_q  <= dsel_wb_d;
            ex_load_q  <= ex_load_d;
        end
    end

`ifdef REGSEL_FWD_EN
    logic [1:0] fwd_a_d, fwd_a_q;
    logic [1:0] fwd_b_d, fwd_b_q;

    // EX match wins over MEM match; a stalled slot carries no forwarding.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (stall_s) begin
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
        end else begin
            fwd_a_d = a_ex_s ? FWD_MEM : (a_mem_s ? FWD_WB : FWD_RF);
            fwd_b_d = b_ex_s ? FWD_MEM : (b_mem_s ? FWD_WB : FWD_RF);
        end
    end

    // Forwarding codes travel with the instruction into EX.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign bus.fwd_a_EX = fwd_a_q;
    assign bus.fwd_b_EX = fwd_b_q;
`endif

    assign bus.Asel     = asel_s;
    assign bus.Bsel     = bsel_s;
    assign bus.Dsel_EX  = dsel_ex_q;
    assign bus.Dsel_MEM = dsel_mem_q;
    assign bus.Dsel_WB  = dsel_wb_q;
    assign bus.stall    = stall_s;

endmodule
